sdram_rw_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single bidirectional SDRAM wrapper port (rw_addr/rw_cnt/read_start/write_start/rw_done) between N_REQ NPU requesters, such as the activation loader and the result write-back engine.
- Latches one request at a time, issues the wrapper start pulse, and steers read beats and write-next strobes to the granted requester.
- Counts data beats and raises a sticky error if a transfer ends with the wrong beat count.

---
 rtl/sdram_rw_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sdram_rw_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter
//   Shares the single SDRAM wrapper port between N_REQ requesters. Requests are
//   picked round-robin, one at a time. The arbiter issues the wrapper start
//   pulse, steers read beats and write-next strobes to the granted requester,
//   and counts beats. cnt_err is a sticky flag. It is set when a transfer ends
//   with a beat count that differs from the request, and when wrapper activity
//   arrives outside a transfer.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   req_valid/req_write    per-requester request and direction (1 = write)
//   req_addr/req_cnt       per-requester byte address / beat count (packed)
//   req_ready/req_done     one-cycle accept / completion pulses
//   rd_valid/rd_data       read beats routed to the granted requester
//   wr_nxt/wr_data         write-beat strobe out, per-requester write data in
//   rw_addr/rw_cnt         latched transfer descriptor to the wrapper
//   read_start/write_start one-cycle wrapper start pulses
//   rw_done/read_valid/read_data/write_nxt/write_data  wrapper handshake
//   busy, grant_id, cnt_err  status
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | scan requesters from rr_ptr, latch the winner's descriptor
// ISSUE | start pulse + req_ready (req_done too for zero-length), 1 cycle
// XFER  | route beats, count them, wait for rw_done
// GAP   | one turnaround cycle for the wrapper
module sdram_rw_arbiter #(
  parameter int N_REQ   = 2,
  parameter int SDRAM_W = 128,
  parameter int CNT_W   = 11,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*32-1:0]      req_addr,
  input  logic [N_REQ*CNT_W-1:0]   req_cnt,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_done,
  output logic [N_REQ-1:0]         rd_valid,
  output logic [SDRAM_W-1:0]       rd_data,
  output logic [N_REQ-1:0]         wr_nxt,
  input  logic [N_REQ*SDRAM_W-1:0] wr_data,
  output logic [31:0]              rw_addr,
  output logic [CNT_W-1:0]         rw_cnt,
  output logic                     read_start,
  output logic                     write_start,
  input  logic                     rw_done,
  input  logic                     read_valid,
  input  logic [SDRAM_W-1:0]       read_data,
  input  logic                     write_nxt,
  output logic [SDRAM_W-1:0]       write_data,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     cnt_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]     rr_ptr;
  logic [31:0]        lat_addr;
  logic [CNT_W-1:0]   lat_cnt;
  logic               lat_write;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beat_total;
  logic               beat;
  logic               zero_len;
  logic               stray;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  int                 cand;
  logic [IDW-1:0]     cand_idx;

  logic [31:0]        addr_a  [N_REQ];
  logic [CNT_W-1:0]   cnt_a   [N_REQ];
  logic [SDRAM_W-1:0] wdata_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*32 +: 32];
    assign cnt_a[g]   = req_cnt[g*CNT_W +: CNT_W];
    assign wdata_a[g] = wr_data[g*SDRAM_W +: SDRAM_W];
  end

  // Round-robin pick. Scanning from the farthest offset down to offset 0 leaves
  // the requester nearest rr_ptr as the final winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDW-1:0];
      if (req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign zero_len = (lat_cnt == '0);
  assign beat     = lat_write ? write_nxt : read_valid;
  // The counter saturates at its maximum, so a runaway wrapper cannot wrap it
  // back to a count that happens to match the request.
  assign beat_total = (beat && !(&beat_cnt)) ? beat_cnt + CNT_W'(1) : beat_cnt;
  assign stray      = rw_done | read_valid | write_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_found) state_nxt = ISSUE;
      ISSUE: state_nxt = zero_len ? GAP : XFER;
      XFER:  if (rw_done) state_nxt = GAP;
      GAP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      lat_addr  <= '0;
      lat_cnt   <= '0;
      lat_write <= 1'b0;
      beat_cnt  <= '0;
      cnt_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            lat_addr  <= addr_a[pick_idx];
            lat_cnt   <= cnt_a[pick_idx];
            lat_write <= req_write[pick_idx];
          end
        end
        ISSUE: begin
          rr_ptr   <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
          beat_cnt <= '0;
        end
        XFER: begin
          beat_cnt <= beat_total;
          if (rw_done && (beat_total != lat_cnt)) cnt_err <= 1'b1;
        end
        default: ;
      endcase
      if (state != XFER && stray) cnt_err <= 1'b1;
    end
  end

  // rw_addr/rw_cnt follow the latch registers. Those registers change only on
  // the IDLE->ISSUE edge, so the outputs hold their value through IDLE and GAP.
  assign rw_addr = lat_addr;
  assign rw_cnt  = lat_cnt;
  assign busy    = (state != IDLE);

  always_comb begin
    req_ready   = '0;
    req_done    = '0;
    rd_valid    = '0;
    rd_data     = '0;
    wr_nxt      = '0;
    write_data  = '0;
    read_start  = 1'b0;
    write_start = 1'b0;
    case (state)
      ISSUE: begin
        req_ready[grant_id] = 1'b1;
        if (zero_len)       req_done[grant_id] = 1'b1;
        else if (lat_write) write_start = 1'b1;
        else                read_start  = 1'b1;
      end
      XFER: begin
        if (lat_write) begin
          wr_nxt[grant_id] = write_nxt;
          write_data       = wdata_a[grant_id];
        end else begin
          rd_valid[grant_id] = read_valid;
          rd_data            = read_data;
        end
        if (rw_done) req_done[grant_id] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
module tb_sdram_rw_arbiter;

  localparam int N_REQ   = 2;
  localparam int SDRAM_W = 128;
  localparam int CNT_W   = 11;

  logic                     clk;
  logic                     rst_n;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_write;
  logic [N_REQ*32-1:0]      req_addr;
  logic [N_REQ*CNT_W-1:0]   req_cnt;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         req_done;
  logic [N_REQ-1:0]         rd_valid;
  logic [SDRAM_W-1:0]       rd_data;
  logic [N_REQ-1:0]         wr_nxt;
  logic [N_REQ*SDRAM_W-1:0] wr_data;
  logic [31:0]              rw_addr;
  logic [CNT_W-1:0]         rw_cnt;
  logic                     read_start;
  logic                     write_start;
  logic                     rw_done;
  logic                     read_valid;
  logic [SDRAM_W-1:0]       read_data;
  logic                     write_nxt;
  logic [SDRAM_W-1:0]       write_data;
  logic                     busy;
  logic [0:0]               grant_id;
  logic                     cnt_err;

  int vectors;
  int miscompares;
  logic [SDRAM_W-1:0] exp_d;

  sdram_rw_arbiter #(.N_REQ(N_REQ), .SDRAM_W(SDRAM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_cnt(req_cnt),
    .req_ready(req_ready), .req_done(req_done),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_nxt(wr_nxt), .wr_data(wr_data),
    .rw_addr(rw_addr), .rw_cnt(rw_cnt), .read_start(read_start), .write_start(write_start),
    .rw_done(rw_done), .read_valid(read_valid), .read_data(read_data),
    .write_nxt(write_nxt), .write_data(write_data),
    .busy(busy), .grant_id(grant_id), .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_cnt = '0; wr_data = '0;
    rw_done = 1'b0; read_valid = 1'b0; read_data = '0; write_nxt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cnt_err", cnt_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_read_start", read_start, 0);
    chk("rst_rw_addr", rw_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;
    tick();

    // single read, req 0, 4 beats
    req_valid = 2'b01; req_write = 2'b00;
    req_addr[31:0] = 32'h3000_0000; req_cnt[10:0] = 11'd4;
    #1;
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_start", read_start, 0);
    tick();
    chk("rd_issue_start", read_start, 1);
    chk("rd_issue_wstart", write_start, 0);
    chk("rd_issue_ready", req_ready, 2'b01);
    chk("rd_issue_addr", rw_addr, 32'h3000_0000);
    chk("rd_issue_cnt", rw_cnt, 4);
    chk("rd_issue_gid", grant_id, 0);
    tick();
    req_valid = 2'b00;
    #1;
    chk("rd_xfer_start", read_start, 0);
    for (int k = 0; k < 4; k++) begin
      exp_d = {4{32'hA5A5_0000 + 32'(k)}};
      read_valid = 1'b1; read_data = exp_d;
      #1;
      chk("rd_beat_valid", rd_valid, 2'b01);
      chk("rd_beat_data", rd_data, exp_d);
      tick();
    end
    read_valid = 1'b0; read_data = '0; rw_done = 1'b1;
    #1;
    chk("rd_done", req_done, 2'b01);
    tick();
    rw_done = 1'b0;
    #1;
    chk("rd_gap_busy", busy, 1);
    chk("rd_gap_done", req_done, 0);
    chk("rd_cnt_err", cnt_err, 0);
    tick();
    chk("rd_idle_after", busy, 0);

    // single write, req 1, 3 beats; last beat arrives with rw_done
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[63:32] = 32'h3000_0100; req_cnt[21:11] = 11'd3;
    wr_data[127:0] = {4{32'hDEAD_BEEF}};
    #1;
    tick();
    chk("wr_issue_wstart", write_start, 1);
    chk("wr_issue_rstart", read_start, 0);
    chk("wr_issue_ready", req_ready, 2'b10);
    chk("wr_issue_gid", grant_id, 1);
    chk("wr_issue_addr", rw_addr, 32'h3000_0100);
    chk("wr_issue_cnt", rw_cnt, 3);
    tick();
    req_valid = 2'b00;
    #1;
    chk("wr_xfer_wstart", write_start, 0);
    for (int k = 0; k < 3; k++) begin
      exp_d = {4{32'h1111_0000 + 32'(k)}};
      wr_data[255:128] = exp_d;
      write_nxt = 1'b1;
      rw_done = (k == 2);
      #1;
      chk("wr_beat_data", write_data, exp_d);
      chk("wr_beat_nxt", wr_nxt, 2'b10);
      if (k == 2) chk("wr_done", req_done, 2'b10);
      tick();
    end
    write_nxt = 1'b0; rw_done = 1'b0;
    #1;
    chk("wr_cnt_err", cnt_err, 0);
    tick();
    req_write = 2'b00;

    // fairness: both requesters valid for 6 single-beat reads
    req_cnt[10:0] = 11'd1; req_cnt[21:11] = 11'd1; req_valid = 2'b11;
    #1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("fair_gid", grant_id, t % 2);
      chk("fair_ready", req_ready, (t % 2) ? 2'b10 : 2'b01);
      tick();
      read_valid = 1'b1; rw_done = 1'b1;
      #1;
      chk("fair_done", req_done, (t % 2) ? 2'b10 : 2'b01);
      tick();
      read_valid = 1'b0; rw_done = 1'b0;
      if (t == 5) req_valid = 2'b00;
      tick();
    end
    chk("fair_cnt_err", cnt_err, 0);

    // zero-length request on req 0
    req_valid = 2'b01; req_cnt[10:0] = 11'd0;
    #1;
    tick();
    chk("zl_ready", req_ready, 2'b01);
    chk("zl_done", req_done, 2'b01);
    chk("zl_rstart", read_start, 0);
    chk("zl_wstart", write_start, 0);
    chk("zl_busy1", busy, 1);
    req_valid = 2'b00;
    tick();
    chk("zl_busy2", busy, 1);
    chk("zl_done_gap", req_done, 0);
    tick();
    chk("zl_idle", busy, 0);
    chk("zl_cnt_err", cnt_err, 0);

    // count error: cnt=4, wrapper returns 3 beats
    req_valid = 2'b01; req_cnt[10:0] = 11'd4;
    #1;
    tick();
    chk("ce_gid", grant_id, 0);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      read_valid = 1'b1;
      tick();
    end
    read_valid = 1'b0; rw_done = 1'b1;
    #1;
    chk("ce_done", req_done, 2'b01);
    tick();
    rw_done = 1'b0;
    #1;
    chk("ce_err_set", cnt_err, 1);
    tick();
    req_valid = 2'b10; req_cnt[21:11] = 11'd1;
    #1;
    tick();
    tick();
    req_valid = 2'b00; read_valid = 1'b1; rw_done = 1'b1;
    #1;
    chk("ce_good_done", req_done, 2'b10);
    tick();
    read_valid = 1'b0; rw_done = 1'b0;
    tick();
    chk("ce_err_sticky", cnt_err, 1);

    // reset in the middle of an 8-beat read on req 0
    req_valid = 2'b01; req_cnt[10:0] = 11'd8; req_addr[31:0] = 32'h3000_0200;
    #1;
    tick();
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      read_valid = 1'b1; read_data = {4{32'h5555_0000 + 32'(k)}};
      tick();
    end
    read_valid = 1'b1; read_data = {4{32'h7777_7777}};
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_rw_addr", rw_addr, 0);
    chk("mr_rw_cnt", rw_cnt, 0);
    chk("mr_cnt_err", cnt_err, 0);
    chk("mr_grant_id", grant_id, 0);
    chk("mr_req_done", req_done, 0);
    read_valid = 1'b0; read_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11; req_cnt[10:0] = 11'd1; req_cnt[21:11] = 11'd1;
    #1;
    tick();
    chk("mr_first_gid", grant_id, 0);
    tick();
    read_valid = 1'b1; rw_done = 1'b1;
    #1;
    chk("mr_first_done", req_done, 2'b01);
    tick();
    read_valid = 1'b0; rw_done = 1'b0;
    tick();
    tick();
    chk("mr_second_gid", grant_id, 1);
    chk("mr_second_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00; read_valid = 1'b1; rw_done = 1'b1;
    #1;
    chk("mr_second_done", req_done, 2'b10);
    tick();
    read_valid = 1'b0; rw_done = 1'b0;
    tick();
    chk("mr_end_busy", busy, 0);
    chk("mr_end_cnt_err", cnt_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
